// File: rtl/residual_add_stage_if.sv
// Stream bundle for residual_add_stage: skip/attention inputs, residual-sum output, status.
// The slave modport is the stage's view; master is the surrounding datapath.
interface residual_add_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SKIP_DEPTH = 8
);
  localparam int CW = $clog2(SKIP_DEPTH) + 1;

  logic                  cfg_start;
  logic                  skip_valid;
  logic                  skip_ready;
  logic [DATA_WIDTH-1:0] skip_data;
  logic                  attn_valid;
  logic                  attn_ready;
  logic [DATA_WIDTH-1:0] attn_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CW-1:0]         skip_count;
  logic                  sat_flag;

  modport slave (
    input  cfg_start,
    input  skip_valid, skip_data,
    output skip_ready,
    input  attn_valid, attn_data,
    output attn_ready,
    output out_valid, out_data,
    input  out_ready,
    output skip_count, sat_flag
  );

  modport master (
    output cfg_start,
    output skip_valid, skip_data,
    input  skip_ready,
    output attn_valid, attn_data,
    input  attn_ready,
    input  out_valid, out_data,
    output out_ready,
    input  skip_count, sat_flag
  );
endinterface

// File: rtl/residual_add_stage.sv
// Residual join: skip FIFO of x_t, joined with attention result y_t, registered x_t + y_t output.
// Optional macro RESIDUAL_SAT_EN: saturating add with sticky sat_flag (default: wrapping add).
module residual_add_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int SKIP_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  residual_add_stage_if.slave bus
);
  localparam int AW = $clog2(SKIP_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [SKIP_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  sat_flag_q;

  logic                  full;
  logic                  push;
  logic                  fire;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] sum_next;
  logic                  sat_hit;

  assign full = (count == CW'(SKIP_DEPTH));
  assign head = mem[rd_ptr];

  // Readies depend only on registered state, rst, cfg_start and out_ready.
  assign bus.skip_ready = !rst && !full && !bus.cfg_start;
  assign bus.attn_ready = !rst && (count != '0) && (!out_valid_q || bus.out_ready) && !bus.cfg_start;

  assign push = bus.skip_valid && bus.skip_ready;
  assign fire = bus.attn_valid && bus.attn_ready;

`ifdef RESIDUAL_SAT_EN
  logic [DATA_WIDTH:0] sum_ext;
  assign sum_ext = {head[DATA_WIDTH-1], head} + {bus.attn_data[DATA_WIDTH-1], bus.attn_data};
  assign sat_hit = sum_ext[DATA_WIDTH] ^ sum_ext[DATA_WIDTH-1];
  always_comb begin
    sum_next = sum_ext[DATA_WIDTH-1:0];
    if (sat_hit)
      sum_next = sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  assign sum_next = head + bus.attn_data;
  assign sat_hit  = 1'b0;
`endif

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.skip_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_flag_q  <= 1'b0;
    end else if (bus.cfg_start) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (fire) begin
        rd_ptr      <= rd_ptr + 1'b1;
        out_data_q  <= sum_next;
        out_valid_q <= 1'b1;
        if (sat_hit)
          sat_flag_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case ({push, fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.skip_count = count;
  assign bus.sat_flag   = sat_flag_q;
endmodule
